pu_result_drain: RTL



---
 rtl/pu_pkg.sv | 43 ++++
 rtl/pu_sat_shift.sv | 30 +++
 rtl/pu_result_drain.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/pu_pkg.sv
// Shared definitions for the PU result drain: FSM encodings, index width
// helper and the per-element rescale/saturate function.
package pu_pkg;

  // Drain FSM encodings
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  // Working width of the rescale arithmetic; covers any WIDTH_IN up to 64
  localparam int SAT_W = 64;

  // Index width for a vector of n elements; never narrower than one bit
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Sign-extend the low width_in bits of x, shift right arithmetically by
  // shift, then clamp into a width_o signed range.
  // Returns {sat, value}; the caller keeps value[width_o-1:0].
  function automatic logic [SAT_W:0] sat_shift(
    input logic [SAT_W-1:0] x,
    input int               shift,
    input int               width_in,
    input int               width_o
  );
    logic signed [SAT_W-1:0] xs;
    logic signed [SAT_W-1:0] s;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    xs = $signed(x << (SAT_W - width_in)) >>> (SAT_W - width_in);
    s  = xs >>> shift;
    hi = (64'sd1 <<< (width_o - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width_o - 1));
    if (s > hi) begin
      return {1'b1, hi};
    end else if (s < lo) begin
      return {1'b1, lo};
    end else begin
      return {1'b0, s};
    end
  endfunction

endpackage

// File: rtl/pu_sat_shift.sv
// Combinational rescale of one PU accumulator element: arithmetic right
// shift followed by saturation to a narrower signed width.
module pu_sat_shift #(
  parameter int WIDTH_IN = 32,
  parameter int WIDTH_O  = 16,
  parameter int SHIFT    = 0
) (
  input  logic [WIDTH_IN-1:0] x,
  output logic [WIDTH_O-1:0]  y,
  output logic                sat
);
  import pu_pkg::*;

  logic [SAT_W-1:0] x_ext;
  logic [SAT_W:0]   res;
  logic             unused_res;

  // Widen the element and apply the shared shift/clamp function
  always_comb begin
    x_ext                 = '0;
    x_ext[WIDTH_IN-1:0]   = x;
    res                   = sat_shift(x_ext, SHIFT, WIDTH_IN, WIDTH_O);
  end

  assign y          = res[WIDTH_O-1:0];
  assign sat        = res[SAT_W];
  // Upper bits are pure sign/clamp extension and carry no information
  assign unused_res = ^res[SAT_W-1:WIDTH_O];

endmodule

// File: rtl/pu_result_drain.sv
// PU result drain: captures the packed accumulator vector on a DONE rising
// edge, rescales/saturates every element in the capture cycle, then streams
// the elements one per beat over valid/ready with index, last and sat flags.
module pu_result_drain
  import pu_pkg::*;
#(
  parameter int  WIDTH_IN   = 32,
  parameter int  MATRIX_ROW = 8,
  parameter int  WIDTH_O    = 16,
  parameter int  SHIFT      = 0,
  localparam int IDX_W      = idx_w(MATRIX_ROW)
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [WIDTH_IN*MATRIX_ROW-1:0] IN_VEC,
  input  logic                           IN_DONE,
  output logic [WIDTH_O-1:0]             M_DATA,
  output logic [IDX_W-1:0]               M_IDX,
  output logic                           M_SAT,
  output logic                           M_LAST,
  output logic                           M_VALID,
  input  logic                           M_READY,
  output logic                           BUSY,
  output logic                           OVERRUN
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MATRIX_ROW - 1);

  logic               done_q_reg;
  logic [0:0]         state_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic               overrun_reg;
  logic [WIDTH_O-1:0] conv_data [MATRIX_ROW];
  logic               conv_sat  [MATRIX_ROW];
  logic [WIDTH_O-1:0] cap_data_reg [MATRIX_ROW];
  logic               cap_sat_reg  [MATRIX_ROW];

  logic start;
  logic send;
  logic capture;
  logic beat_done;

  assign start     = IN_DONE & ~done_q_reg;
  assign send      = (state_reg == ST_SEND);
  assign capture   = start & ~send;
  assign beat_done = send & M_READY;

  // One converter per element so the whole vector lands in a single cycle
  genvar gi;
  generate
    for (gi = 0; gi < MATRIX_ROW; gi++) begin : g_conv
      pu_sat_shift #(
        .WIDTH_IN (WIDTH_IN),
        .WIDTH_O  (WIDTH_O),
        .SHIFT    (SHIFT)
      ) u_conv (
        .x   (IN_VEC[WIDTH_IN*gi +: WIDTH_IN]),
        .y   (conv_data[gi]),
        .sat (conv_sat[gi])
      );
    end
  endgenerate

  // DONE history for rising-edge detection; cleared by reset so a DONE
  // still high afterwards counts as a fresh edge
  always_ff @(posedge CLK) begin
    if (RST) begin
      done_q_reg <= 1'b0;
    end else begin
      done_q_reg <= IN_DONE;
    end
  end

  // Drain FSM and beat index
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg <= ST_SEND;
            idx_reg   <= '0;
          end
        end
        ST_SEND: begin
          if (beat_done) begin
            if (idx_reg == LAST_IDX) begin
              state_reg <= ST_IDLE;
              idx_reg   <= '0;
            end else begin
              idx_reg <= idx_reg + IDX_W'(1);
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          idx_reg   <= '0;
        end
      endcase
    end
  end

  // Capture bank: loaded only from IDLE, untouched while a vector drains
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < MATRIX_ROW; k++) begin
        cap_data_reg[k] <= '0;
        cap_sat_reg[k]  <= 1'b0;
      end
    end else if (capture) begin
      for (int k = 0; k < MATRIX_ROW; k++) begin
        cap_data_reg[k] <= conv_data[k];
        cap_sat_reg[k]  <= conv_sat[k];
      end
    end
  end

  // Sticky flag for a result that arrived while the previous one drained
  always_ff @(posedge CLK) begin
    if (RST) begin
      overrun_reg <= 1'b0;
    end else if (start && send) begin
      overrun_reg <= 1'b1;
    end
  end

  // Output mux: present element idx while sending, zeros otherwise
  always_comb begin
    M_DATA  = '0;
    M_SAT   = 1'b0;
    M_LAST  = 1'b0;
    M_IDX   = idx_reg;
    M_VALID = send;
    BUSY    = send;
    OVERRUN = overrun_reg;
    if (send) begin
      M_DATA = cap_data_reg[idx_reg];
      M_SAT  = cap_sat_reg[idx_reg];
      M_LAST = (idx_reg == LAST_IDX);
    end
  end

endmodule
